// File: rtl/proc_run_ctrl.sv
// Run controller: holds a processor in reset while its PC is loaded, then steps it
// until it reaches a halt PC, hits an instruction limit, or is aborted.
module proc_run_ctrl #(
  parameter int unsigned RESET_HOLD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] start_pc,
  input  logic [31:0] halt_pc,
  input  logic [15:0] max_cycles,
  input  logic        abort,
  input  logic        clear,
  input  logic [31:0] pc_in,
  input  logic [31:0] z_in,
  output logic        proc_reset,
  output logic [31:0] load_pc,
  output logic        clk_en,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [15:0] cycle_count,
  output logic [31:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_HALT    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

  localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  hold_q, hold_d;
  logic [31:0] start_pc_q, start_pc_d;
  logic [31:0] halt_pc_q, halt_pc_d;
  logic [15:0] limit_q, limit_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] result_q, result_d;
  logic        at_halt, at_limit, relatch;

  assign at_halt  = (pc_in == halt_pc_q);
  assign at_limit = (count_q == limit_q);

  assign clk_en      = (state_q == RUN) && !abort && !at_halt && !at_limit;
  assign proc_reset  = (state_q == IDLE) || (state_q == LOAD);
  assign load_pc     = (state_q == IDLE) ? 32'h0 : start_pc_q;
  assign busy        = (state_q == LOAD) || (state_q == RUN);
  assign done        = (state_q == DONE);
  assign status      = status_q;
  assign cycle_count = count_q;
  assign result      = result_q;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    start_pc_d = start_pc_q;
    halt_pc_d  = halt_pc_q;
    limit_d    = limit_q;
    count_d    = count_q;
    status_d   = status_q;
    result_d   = result_q;
    relatch    = 1'b0;

    case (state_q)
      IDLE: relatch = start;
      LOAD: begin
        if (abort) begin
          state_d  = DONE;
          status_d = ST_ABORT;
          result_d = z_in;
          hold_d   = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      RUN: begin
        // Exit priority: abort, then halt PC, then instruction limit.
        if (abort || at_halt || at_limit) begin
          state_d  = DONE;
          result_d = z_in;
          status_d = abort ? ST_ABORT : (at_halt ? ST_HALT : ST_TIMEOUT);
        end else begin
          count_d = count_q + 16'd1;
        end
      end
      default: begin
        if (start) begin
          relatch = 1'b1;
        end else if (clear) begin
          state_d = IDLE;
        end
      end
    endcase

    if (relatch) begin
      state_d    = LOAD;
      hold_d     = '0;
      start_pc_d = start_pc;
      halt_pc_d  = halt_pc;
      limit_d    = (max_cycles == 16'h0) ? 16'hFFFF : max_cycles;
      count_d    = '0;
      status_d   = ST_NONE;
      result_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      start_pc_q <= '0;
      halt_pc_q  <= '0;
      limit_q    <= '0;
      count_q    <= '0;
      status_q   <= ST_NONE;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      start_pc_q <= start_pc_d;
      halt_pc_q  <= halt_pc_d;
      limit_q    <= limit_d;
      count_q    <= count_d;
      status_q   <= status_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Scoreboard bench for proc_run_ctrl: a toy processor steps PC by 4 when enabled and
// expected run outcomes from a reference model are queued at start and checked at done.
module tb_proc_run_ctrl;

  localparam int unsigned RESET_HOLD = 2;
  localparam logic [31:0] ZMASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, clear;
  logic [31:0] start_pc, halt_pc, pc_in, z_in, load_pc, result;
  logic [15:0] max_cycles, cycle_count;
  logic        proc_reset, clk_en, busy, done;
  logic [1:0]  status;

  typedef struct {
    logic [1:0]  st;
    logic [15:0] cnt;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  proc_run_ctrl #(.RESET_HOLD(RESET_HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_pc   (start_pc),
    .halt_pc    (halt_pc),
    .max_cycles (max_cycles),
    .abort      (abort),
    .clear      (clear),
    .pc_in      (pc_in),
    .z_in       (z_in),
    .proc_reset (proc_reset),
    .load_pc    (load_pc),
    .clk_en     (clk_en),
    .busy       (busy),
    .done       (done),
    .status     (status),
    .cycle_count(cycle_count),
    .result     (result)
  );

  always #5 clk = ~clk;

  // Toy processor: PC loads while held in reset, advances by 4 on each enabled step.
  always @(posedge clk) begin
    if (proc_reset) pc_in <= load_pc;
    else if (clk_en) pc_in <= pc_in + 32'd4;
  end
  assign z_in = pc_in ^ ZMASK;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference outcome of one run; abort_k is the 1-based RUN cycle carrying abort (0 = none).
  function automatic exp_t ref_run(logic [31:0] spc, logic [31:0] hpc, logic [15:0] maxc,
                                   int abort_k, bit abort_load);
    exp_t e;
    logic [31:0] pc = spc;
    logic [15:0] lim = (maxc == 16'h0) ? 16'hFFFF : maxc;
    e.cnt = '0;
    if (abort_load) begin
      e.st = 2'b11;
      e.res = spc ^ ZMASK;
      return e;
    end
    for (int k = 1; k < 70000; k++) begin
      if (k == abort_k) begin e.st = 2'b11; break; end
      if (pc == hpc) begin e.st = 2'b01; break; end
      if (e.cnt == lim) begin e.st = 2'b10; break; end
      e.cnt++;
      pc += 32'd4;
    end
    e.res = pc ^ ZMASK;
    return e;
  endfunction

  task automatic run_case(string tag, logic [31:0] spc, logic [31:0] hpc, logic [15:0] maxc,
                          int abort_k, bit abort_load, bit poke, bit with_clear);
    exp_t e;
    int lk = 0, rk = 0, pulses = 0;
    bit fin = 0;
    sb.push_back(ref_run(spc, hpc, maxc, abort_k, abort_load));
    @(negedge clk);
    start = 1'b1; clear = with_clear;
    start_pc = spc; halt_pc = hpc; max_cycles = maxc;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (done) begin
        fin = 1;
      end else begin
        if (proc_reset) begin
          lk++;
          abort = abort_load && (lk == 2);
        end else begin
          rk++;
          abort = (rk == abort_k);
          if (poke && rk == 2) begin
            start = 1'b1; start_pc = spc + 32'h40; halt_pc = hpc - 32'd4; max_cycles = 16'd1;
          end
        end
        #1;
        if (proc_reset) begin
          check_eq({tag, ".load_pc"}, load_pc, spc);
          check_eq({tag, ".load_clr"}, {busy, done, status, cycle_count}, {2'b10, 18'h0});
        end
        if (clk_en) pulses++;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        start_pc = spc; halt_pc = hpc; max_cycles = maxc;
      end
    end
    if (!fin) begin
      check_eq({tag, ".timeout"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check_eq({tag, ".status"}, status, e.st);
    check_eq({tag, ".count"}, cycle_count, e.cnt);
    check_eq({tag, ".result"}, result, e.res);
    check_eq({tag, ".pulses"}, pulses, e.cnt);
    check_eq({tag, ".load_cycles"}, lk, RESET_HOLD);
    check_eq({tag, ".done_outs"}, {busy, clk_en, proc_reset, load_pc}, {3'b000, spc});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq({tag, ".abort_in_done"}, {done, status}, {1'b1, e.st});
  endtask

  task automatic do_clear(string tag);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    check_eq({tag, ".idle"}, {busy, done, proc_reset, clk_en, load_pc}, {4'b0010, 32'h0});
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; clear = 1'b0;
    start_pc = '0; halt_pc = '0; max_cycles = '0;
    #3;
    check_eq("reset_outs", {proc_reset, clk_en, busy, done, status, cycle_count},
             {4'b1000, 18'h0});
    check_eq("reset_data", {load_pc, result}, 64'h0);
    @(negedge clk);
    reset = 1'b1;

    // Abort and clear while idle must do nothing.
    abort = 1'b1; clear = 1'b1;
    @(negedge clk);
    abort = 1'b0; clear = 1'b0;
    #1;
    check_eq("idle_ignore", {busy, done, proc_reset, status}, {3'b001, 2'b00});

    run_case("halt", 32'h0040_0020, 32'h0040_0030, 16'd0, 0, 0, 0, 0);
    do_clear("halt");
    run_case("limit", 32'h0000_1000, 32'hFFFF_FFF0, 16'd3, 0, 0, 0, 0);
    do_clear("limit");
    run_case("abort_run", 32'h0000_2000, 32'h0000_2100, 16'd0, 2, 0, 0, 0);
    do_clear("abort_run");
    run_case("abort_load", 32'h0000_2400, 32'h0000_2500, 16'd0, 0, 1, 0, 0);
    do_clear("abort_load");
    run_case("halt_eq_start", 32'h0000_3300, 32'h0000_3300, 16'd9, 0, 0, 0, 0);
    do_clear("halt_eq_start");
    run_case("start_in_run", 32'h0000_3000, 32'h0000_3008, 16'd0, 0, 0, 1, 0);
    // Restart straight from DONE with start and clear both high.
    run_case("restart", 32'h0040_0100, 32'h0040_0110, 16'd0, 0, 0, 0, 1);
    do_clear("restart");

    // Reset pulse between edges in the middle of a run.
    @(negedge clk);
    start = 1'b1; start_pc = 32'h0000_5000; halt_pc = 32'h0000_5100; max_cycles = 16'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("pre_reset_run", {busy, proc_reset}, 2'b10);
    #1 reset = 1'b0;
    #1;
    check_eq("mid_reset_outs", {proc_reset, clk_en, busy, done, status, cycle_count},
             {4'b1000, 18'h0});
    check_eq("mid_reset_data", {load_pc, result}, 64'h0);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("post_reset_idle", {busy, done, proc_reset}, 3'b001);

    check_eq("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
